// File: rtl/fetch_ifid_stage.sv
// Fetch stage with PC, single-outstanding imem handshake, skid buffer and IF/ID register.
// Optional IFID_PERF_CNT_EN adds saturating stall and bubble counters.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL_IFID,
  input  logic        FLUSH_IFID,
  input  logic [31:0] AltPC_IN,
  input  logic        AltPCEnable_IN,
  output logic        IMemReq_OUT,
  output logic [31:0] IMemAddr_OUT,
  input  logic        IMemReady_IN,
  input  logic [31:0] IMemData_IN,
  output logic [31:0] Instr_OUT,
  output logic [31:0] PCPlus4_OUT,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0] StallCount_OUT,
  output logic [31:0] BubbleCount_OUT,
`endif
  output logic        Valid_OUT
);

  typedef enum logic {REQ, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc4, buf_pc4_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc4_q, pc4_n;
  logic        valid_q, valid_n;
  logic        stall;
  logic        bubble;
  logic [31:0] pc_plus4;
  logic [31:0] alt_pc;

  // A lone flush still has to freeze fetch.
  assign stall    = STALL_IFID | FLUSH_IFID;
  assign pc_plus4 = pc + 32'd4;
  assign alt_pc   = AltPC_IN & ~32'd3;

  assign IMemReq_OUT  = (state == REQ);
  assign IMemAddr_OUT = pc;
  assign Instr_OUT    = instr_q;
  assign PCPlus4_OUT  = pc4_q;
  assign Valid_OUT    = valid_q;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_pc4_n   = buf_pc4;
    instr_n     = instr_q;
    pc4_n       = pc4_q;
    valid_n     = valid_q;
    bubble      = 1'b0;
    if (state == REQ) begin
      unique case (1'b1)
        (~stall & AltPCEnable_IN): begin
          pc_n   = alt_pc;
          bubble = 1'b1;
        end
        (~stall & ~AltPCEnable_IN & IMemReady_IN): begin
          instr_n = IMemData_IN;
          pc4_n   = pc_plus4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
        end
        (stall & IMemReady_IN): begin
          buf_instr_n = IMemData_IN;
          buf_pc4_n   = pc_plus4;
          state_n     = HOLD;
          bubble      = FLUSH_IFID;
        end
        (~IMemReady_IN & (stall | ~AltPCEnable_IN)): begin
          bubble = ~(STALL_IFID & ~FLUSH_IFID);
        end
        default: ;
      endcase
    end else begin
      unique case (1'b1)
        stall: begin
          bubble = FLUSH_IFID;
        end
        (~stall & AltPCEnable_IN): begin
          pc_n    = alt_pc;
          bubble  = 1'b1;
          state_n = REQ;
        end
        (~stall & ~AltPCEnable_IN): begin
          instr_n = buf_instr;
          pc4_n   = buf_pc4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
          state_n = REQ;
        end
        default: ;
      endcase
    end
    if (bubble) begin
      instr_n = NOP_INSTR;
      pc4_n   = 32'd0;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= REQ;
      pc        <= RESET_PC;
      buf_instr <= 32'd0;
      buf_pc4   <= 32'd0;
      instr_q   <= NOP_INSTR;
      pc4_q     <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_instr <= buf_instr_n;
      buf_pc4   <= buf_pc4_n;
      instr_q   <= instr_n;
      pc4_q     <= pc4_n;
      valid_q   <= valid_n;
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      StallCount_OUT  <= 32'd0;
      BubbleCount_OUT <= 32'd0;
    end else begin
      if (stall && StallCount_OUT != 32'hFFFFFFFF)
        StallCount_OUT <= StallCount_OUT + 32'd1;
      if (bubble && BubbleCount_OUT != 32'hFFFFFFFF)
        BubbleCount_OUT <= BubbleCount_OUT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Randomized self-checking bench for fetch_ifid_stage against a transaction-level model.
// Directed prologue covers the basic stream, stall/flush, redirect, PC wrap and async reset.
module tb_fetch_ifid_stage;

  localparam logic [31:0] RST_PC = 32'h00400000;
  localparam logic [31:0] NOP    = 32'h00000000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL_IFID = 1'b0;
  logic        FLUSH_IFID = 1'b0;
  logic [31:0] AltPC_IN = 32'd0;
  logic        AltPCEnable_IN = 1'b0;
  logic        IMemReq_OUT;
  logic [31:0] IMemAddr_OUT;
  logic        IMemReady_IN = 1'b0;
  logic [31:0] IMemData_IN = 32'd0;
  logic [31:0] Instr_OUT;
  logic [31:0] PCPlus4_OUT;
  logic        Valid_OUT;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] StallCount_OUT;
  logic [31:0] BubbleCount_OUT;
`endif

  int checks = 0;
  int errors = 0;

  fetch_ifid_stage dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .STALL_IFID(STALL_IFID),
    .FLUSH_IFID(FLUSH_IFID),
    .AltPC_IN(AltPC_IN),
    .AltPCEnable_IN(AltPCEnable_IN),
    .IMemReq_OUT(IMemReq_OUT),
    .IMemAddr_OUT(IMemAddr_OUT),
    .IMemReady_IN(IMemReady_IN),
    .IMemData_IN(IMemData_IN),
    .Instr_OUT(Instr_OUT),
    .PCPlus4_OUT(PCPlus4_OUT),
`ifdef IFID_PERF_CNT_EN
    .StallCount_OUT(StallCount_OUT),
    .BubbleCount_OUT(BubbleCount_OUT),
`endif
    .Valid_OUT(Valid_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference: a fetch either is outstanding or has landed in a parked slot.
  bit          m_parked;
  logic [31:0] m_pc, m_park_instr, m_park_pc4;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  logic [31:0] m_stalls, m_bubbles;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_parked    = 0;
    m_pc        = RST_PC;
    m_park_instr = 32'd0;
    m_park_pc4  = 32'd0;
    m_instr     = NOP;
    m_pc4       = 32'd0;
    m_valid     = 0;
    m_stalls    = 32'd0;
    m_bubbles   = 32'd0;
  endtask

  task automatic check_all();
    chk("req",   {31'd0, IMemReq_OUT}, {31'd0, !m_parked});
    chk("addr",  IMemAddr_OUT, m_pc);
    chk("instr", Instr_OUT, m_instr);
    chk("pc4",   PCPlus4_OUT, m_pc4);
    chk("valid", {31'd0, Valid_OUT}, {31'd0, m_valid});
`ifdef IFID_PERF_CNT_EN
    chk("stallcnt",  StallCount_OUT, m_stalls);
    chk("bubblecnt", BubbleCount_OUT, m_bubbles);
`endif
  endtask

  task automatic model_step(input bit st_in, input bit fl, input bit ae,
                            input logic [31:0] alt, input bit rdy,
                            input logic [31:0] data);
    bit frozen = st_in || fl;
    bit bub = 0;
    if (!m_parked) begin
      if (ae && !frozen) begin
        m_pc = {alt[31:2], 2'b00};
        bub = 1;
      end else if (rdy && !frozen) begin
        m_instr = data;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1;
        m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_park_instr = data;
        m_park_pc4 = m_pc + 32'd4;
        m_parked = 1;
        bub = fl;
      end else begin
        bub = !(frozen && !fl);
      end
    end else begin
      if (frozen) begin
        bub = fl;
      end else if (ae) begin
        m_parked = 0;
        m_pc = {alt[31:2], 2'b00};
        bub = 1;
      end else begin
        m_parked = 0;
        m_instr = m_park_instr;
        m_pc4 = m_park_pc4;
        m_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end
    if (bub) begin
      m_instr = NOP;
      m_pc4 = 32'd0;
      m_valid = 0;
      if (m_bubbles != 32'hFFFFFFFF) m_bubbles++;
    end
    if (frozen && m_stalls != 32'hFFFFFFFF) m_stalls++;
  endtask

  // Called at a negedge: check, drive this cycle's inputs, advance one cycle.
  task automatic cyc(input bit st_in, input bit fl, input bit ae,
                     input logic [31:0] alt, input bit rdy,
                     input logic [31:0] data);
    bit r = rdy && !m_parked;
    check_all();
    STALL_IFID = st_in;
    FLUSH_IFID = fl;
    AltPCEnable_IN = ae;
    AltPC_IN = alt;
    IMemReady_IN = r;
    IMemData_IN = data;
    model_step(st_in, fl, ae, alt, r, data);
    @(negedge CLOCK);
  endtask

  initial begin
    logic [31:0] alt;
    model_reset();
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    // Stream, stall with parked word, flush, redirect onto a response.
    cyc(0, 0, 0, 0, 1, 32'h11);
    cyc(0, 0, 0, 0, 1, 32'h22);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h11);
    cyc(1, 0, 0, 0, 1, 32'h22);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h33);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h00400103, 1, 32'h44);
    cyc(0, 0, 0, 0, 1, 32'h55);
    // Redirect while parked: ignored under stall, taken once unstalled.
    cyc(1, 0, 0, 0, 1, 32'h66);
    cyc(1, 0, 1, 32'h00400200, 0, 0);
    cyc(0, 0, 1, 32'h00400200, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h77);
    cyc(0, 1, 0, 0, 0, 0);
    // PC wrap, then async reset in mid-request.
    cyc(0, 0, 1, 32'hFFFFFFFF, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h88);
    cyc(0, 0, 0, 0, 0, 0);
    check_all();
    @(posedge CLOCK);
    #2 RESET = 1'b0;
    IMemReady_IN = 1'b0;
    STALL_IFID = 1'b0;
    FLUSH_IFID = 1'b0;
    AltPCEnable_IN = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLOCK);
    RESET = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      alt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | $urandom_range(0, 3))
                                         : $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 6) == 0, alt,
          $urandom_range(0, 2) != 0, $urandom);
    end
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; it is the consumer of the hazard unit's STALL_IFID / FLUSH_IFID pair.
- Owns the PC, issues requests to a multicycle instruction memory with a ready handshake, and buffers a returned instruction when ID is stalled.
- Accepts branch/jump redirects from ID.
- Feeds Instr_OUT / PCPlus4_OUT / Valid_OUT to the decode stage.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded at reset.
- NOP_INSTR, 32'h00000000, instruction word inserted for bubbles.

Ports:
- CLOCK  in  1  clock, posedge.
- RESET  in  1  reset, asynchronous, active-low.
- STALL_IFID  in  1  hold IF/ID register and PC.
- FLUSH_IFID  in  1  load bubble into IF/ID; always accompanied by STALL_IFID.
- AltPC_IN  in  32  branch/jump target from ID.
- AltPCEnable_IN  in  1  redirect request from ID.
- IMemReq_OUT  out  1  fetch request valid.
- IMemAddr_OUT  out  32  fetch address, equals PC.
- IMemReady_IN  in  1  memory response valid this cycle.
- IMemData_IN  in  32  fetched instruction, valid with IMemReady_IN.
- Instr_OUT  out  32  IF/ID instruction.
- PCPlus4_OUT  out  32  IF/ID PC+4 of Instr_OUT.
- Valid_OUT  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, RESET=0): PC=RESET_PC, state=REQ, Instr_OUT=NOP_INSTR, PCPlus4_OUT=0, Valid_OUT=0, skid buffer cleared. A response in flight at reset is discarded; the memory is reset by the same RESET.
- Bubble = Instr_OUT<=NOP_INSTR, PCPlus4_OUT<=0, Valid_OUT<=0.
- PC arithmetic is 32-bit modulo (32'hFFFFFFFC+4 = 0). AltPC_IN[1:0] is forced to 0 on load.
- FSM states: REQ, HOLD.
- REQ outputs: IMemReq_OUT=1, IMemAddr_OUT=PC.
- HOLD outputs: IMemReq_OUT=0; the buffered instruction and its PC+4 are held.
- REQ transitions, evaluated in priority order:
  1. AltPCEnable_IN=1 and STALL_IFID=0: PC<=AltPC_IN&~3, bubble, any response this cycle discarded, stay REQ.
  2. IMemReady_IN=1 and STALL_IFID=0: IF/ID <= {IMemData_IN, PC+4, 1}, PC<=PC+4, stay REQ.
  3. IMemReady_IN=1 and STALL_IFID=1: buffer <= {IMemData_IN, PC+4}, go to HOLD. IF/ID takes a bubble if FLUSH_IFID, else holds.
  4. IMemReady_IN=0: if STALL_IFID=1 and FLUSH_IFID=0, IF/ID holds; otherwise bubble. PC holds, stay REQ.
- HOLD transitions:
  1. STALL_IFID=1: stay HOLD; IF/ID takes a bubble if FLUSH_IFID, else holds. The buffer is retained.
  2. STALL_IFID=0 and AltPCEnable_IN=1: buffer discarded, PC<=AltPC_IN&~3, bubble, go to REQ.
  3. STALL_IFID=0: IF/ID <= {buffer, 1}, PC<=PC+4, go to REQ.
- Redirect with STALL_IFID=1 is ignored; ID re-presents it after the stall clears.
- FLUSH_IFID without STALL_IFID is treated as FLUSH+STALL.
- Latency: instruction appears on Instr_OUT on the cycle after IMemReady_IN when unstalled.
- At most one request is outstanding. IMemReq_OUT and IMemAddr_OUT are stable until IMemReady_IN or a redirect.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- When defined, adds ports StallCount_OUT (out, 32) and BubbleCount_OUT (out, 32), both reset to 0.
- StallCount_OUT increments each cycle STALL_IFID=1.
- BubbleCount_OUT increments each cycle a bubble is loaded into IF/ID.
- Both counters saturate at 32'hFFFFFFFF.
- When not defined, neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset release, memory ready every cycle, words 0x11,0x22,0x33: IMemAddr_OUT 0x00400000, 0x00400004, 0x00400008. Instr_OUT gets 0x11 with PCPlus4_OUT 0x00400004, Valid_OUT=1, one cycle after each ready.
- STALL_IFID=1 for 3 cycles coinciding with ready on 0x00400004 (data 0x22): state HOLD, IMemReq_OUT=0, Instr_OUT holds 0x11. After release, Instr_OUT=0x22, then the next request addr is 0x00400008.
- FLUSH_IFID+STALL_IFID for 1 cycle while IF/ID holds 0x11: next Instr_OUT=0, Valid_OUT=0, PC unchanged. With IFID_PERF_CNT_EN, BubbleCount_OUT +1 and StallCount_OUT +1.
- AltPCEnable_IN=1 with AltPC_IN=0x00400103, coinciding with ready (data 0x44): 0x44 dropped, bubble, next IMemAddr_OUT=0x00400100.
- Redirect in HOLD with STALL_IFID=1 then 0: buffer discarded only on the unstalled cycle, PC=AltPC. Memory ready delayed 4 cycles yields bubbles with Valid_OUT=0.
- PC=0xFFFFFFFC fetch, then RESET low mid-request: PC wraps to 0 before reset. Reset asynchronously restores PC=0x00400000, Valid_OUT=0, state REQ.
